// File: rtl/ram_ahbl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ahbl_pkg
// Shared definitions for the AHB-Lite front end of the 4K x 32 DFFRAM macro:
// HTRANS and HSIZE encodings, plus the controller FSM state type.
// ---------------------------------------------------------------------------
package ram_ahbl_pkg;

    // AHB-Lite transfer types; only NONSEQ and SEQ carry a transfer
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB-Lite transfer sizes supported by the RAM
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Controller states; READ/WRITE/ERR* describe the current data phase
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_WSTALL = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

endpackage

// File: rtl/ram_ahbl_lane_dec.sv
// ---------------------------------------------------------------------------
// ram_ahbl_lane_dec
// Combinational decode of transfer size and low address bits into the four
// byte-lane write enables of the RAM word, plus an alignment/size legality
// flag.
//   size    in  3  HSIZE of the address phase
//   addr_lo in  2  HADDR[1:0] of the address phase
//   lanes   out 4  byte lanes touched (bit n = byte n of the word)
//   legal   out 1  1 = supported size and naturally aligned
// ---------------------------------------------------------------------------
module ram_ahbl_lane_dec
    import ram_ahbl_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] lanes,
    output logic       legal
);

    // Size/offset to lane mask and legality
    always_comb begin
        lanes = 4'b0000;
        legal = 1'b0;
        case (size)
            HSIZE_BYTE: begin
                legal = 1'b1;
                case (addr_lo)
                    2'd0:    lanes = 4'b0001;
                    2'd1:    lanes = 4'b0010;
                    2'd2:    lanes = 4'b0100;
                    2'd3:    lanes = 4'b1000;
                    default: lanes = 4'b0000;
                endcase
            end
            HSIZE_HALF: begin
                legal = ~addr_lo[0];
                if (addr_lo[1]) begin
                    lanes = 4'b1100;
                end else begin
                    lanes = 4'b0011;
                end
            end
            HSIZE_WORD: begin
                legal = (addr_lo == 2'b00);
                lanes = 4'b1111;
            end
            default: begin
                lanes = 4'b0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ram_ahbl_ctrl.sv
// ---------------------------------------------------------------------------
// ram_ahbl_ctrl
// AHB-Lite slave front end for a 2**AW x 32 single-port DFFRAM macro.
// Reads are issued straight from the address phase (zero wait states);
// writes are committed in the data phase from the registered address. When a
// write data phase overlaps a read address phase the port is busy, so one
// wait state (WSTALL) is inserted and the read is issued in the following
// cycle. Illegal sizes / misaligned transfers get a two-cycle ERROR.
//   CLK, RSTn                         clock, async active-low reset
//   HSEL HTRANS HWRITE HSIZE HADDR    AHB-Lite address phase
//   HWDATA HREADY                     write data, bus-level ready
//   HRDATA HREADYOUT HRESP            slave response
//   RAM_EN RAM_WE RAM_A RAM_Di RAM_Do macro port (Do valid one cycle after read)
// ---------------------------------------------------------------------------
module ram_ahbl_ctrl
    import ram_ahbl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          HSEL,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HADDR,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic [31:0]   HRDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic          RAM_EN,
    output logic [3:0]    RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [31:0]   RAM_Di,
    input  logic [31:0]   RAM_Do
);

    state_t        state_r;
    state_t        next_s;
    logic [AW-1:0] addr_r;
    logic [3:0]    lanes_r;
    logic [3:0]    lanes_s;
    logic          legal_s;
    logic          accept_s;
    logic          rd_pending_s;
    logic          hready_s;
    logic          hresp_s;
    logic [31:0]   hrdata_s;
    logic          wr_en_s;
    logic          issue_rd_s;
    logic          unused_s;

    // Upper address bits alias; HTRANS[0] only separates NONSEQ from SEQ
    assign unused_s = ^{HADDR[31:AW+2], HTRANS[0]};

    ram_ahbl_lane_dec u_lane_dec (
        .size    (HSIZE),
        .addr_lo (HADDR[1:0]),
        .lanes   (lanes_s),
        .legal   (legal_s)
    );

    assign accept_s     = HSEL & HTRANS[1] & HREADY;
    // A read sitting in the address phase while the write owns the RAM port
    assign rd_pending_s = (state_r == ST_WRITE) & HSEL & HTRANS[1] & ~HWRITE;

    // Response and write-port drive, decoded from the current data phase
    always_comb begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
        hrdata_s = 32'h0000_0000;
        wr_en_s  = 1'b0;
        case (state_r)
            ST_READ: begin
                hrdata_s = RAM_Do;
            end
            ST_WRITE: begin
                wr_en_s  = 1'b1;
                hready_s = ~rd_pending_s;
            end
            ST_ERR1: begin
                hready_s = 1'b0;
                hresp_s  = 1'b1;
            end
            ST_ERR2: begin
                hresp_s = 1'b1;
            end
            default: begin
                hready_s = 1'b1;
            end
        endcase
    end

    // Reads go to the RAM from the address phase; RSTn gating keeps the
    // macro quiet while reset is held even if the bus shows a read
    assign issue_rd_s = RSTn & hready_s & accept_s & legal_s & ~HWRITE;

    assign HREADYOUT = hready_s;
    assign HRESP     = hresp_s;
    assign HRDATA    = hrdata_s;
    assign RAM_EN    = wr_en_s | issue_rd_s;
    assign RAM_WE    = wr_en_s ? lanes_r : 4'b0000;
    assign RAM_A     = issue_rd_s ? HADDR[AW+1:2] : addr_r;
    assign RAM_Di    = HWDATA;

    // Data-phase state chosen from the address phase being accepted
    always_comb begin
        if (accept_s) begin
            if (!legal_s) begin
                next_s = ST_ERR1;
            end else if (HWRITE) begin
                next_s = ST_WRITE;
            end else begin
                next_s = ST_READ;
            end
        end else begin
            next_s = ST_IDLE;
        end
    end

    // FSM state and registered write address/lanes
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            lanes_r <= 4'b0000;
        end else if (state_r == ST_ERR1) begin
            state_r <= ST_ERR2;
        end else if (rd_pending_s) begin
            state_r <= ST_WSTALL;
        end else begin
            state_r <= next_s;
            if (accept_s && legal_s && HWRITE) begin
                addr_r  <= HADDR[AW+1:2];
                lanes_r <= lanes_s;
            end
        end
    end

endmodule
